// File: rtl/phasecomp_ctrl.sv
// Address/enable sequencer for the OS-PFB phase-compensation ping-pong RAM.
// Writes frame f into one bank while reading frame f-1 reversed and rotated by s_f from the other.
module phasecomp_ctrl #(
    parameter int M     = 8,
    parameter int D     = 6,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     wr_en,
    output logic [$clog2(2*M)-1:0]   wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     rd_en,
    output logic [$clog2(2*M)-1:0]   rd_addr,
    output logic                     dout_valid,
    output logic                     frame_start,
    output logic [$clog2(M)-1:0]     shift_off
);

    localparam int AW = $clog2(2*M);
    localparam int SW = $clog2(M);
    localparam logic [SW:0] D_EXT = D[SW:0];
    localparam logic [SW:0] M_EXT = M[SW:0];

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN_B = 2'd1,
        RUN_A = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     w_q, w_d;
    logic [SW-1:0]     s_q, s_d;
    logic [SW-1:0]     k, rd_idx;
    logic [SW:0]       s_sum, s_wrap;
    logic              last;

    logic              wr_en_q, rd_en_q, dout_valid_q, frame_start_q;
    logic [AW-1:0]     wr_addr_q, rd_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [SW-1:0]     shift_off_q;

    always_comb begin
        k      = w_q[SW-1:0];
        last   = &k;
        w_d    = w_q + AW'(1);
        // Offset step s+D mod M, kept one bit wider so the wrap test sees the carry.
        s_sum  = {1'b0, s_q} + D_EXT;
        s_wrap = s_sum - M_EXT;
        s_d    = (s_sum >= M_EXT) ? s_wrap[SW-1:0] : s_sum[SW-1:0];
        rd_idx = s_q - SW'(1) - k;
        state_d = state_q;
        case (state_q)
            PRIME:   if (last) state_d = RUN_B;
            RUN_B:   if (last) state_d = RUN_A;
            RUN_A:   if (last) state_d = RUN_B;
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= PRIME;
            w_q           <= '0;
            s_q           <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wr_data_q     <= '0;
            shift_off_q   <= '0;
        end else begin
            dout_valid_q <= rd_en_q;
            if (clr) begin
                state_q       <= PRIME;
                w_q           <= '0;
                s_q           <= '0;
                wr_en_q       <= 1'b0;
                rd_en_q       <= 1'b0;
                frame_start_q <= 1'b0;
                wr_addr_q     <= '0;
                rd_addr_q     <= '0;
                wr_data_q     <= '0;
                shift_off_q   <= '0;
            end else if (din_valid) begin
                wr_en_q       <= 1'b1;
                wr_addr_q     <= w_q;
                wr_data_q     <= din;
                rd_en_q       <= (state_q != PRIME);
                rd_addr_q     <= {~w_q[AW-1], rd_idx};
                frame_start_q <= (k == '0);
                if (k == '0) shift_off_q <= s_q;
                w_q <= w_d;
                if (last) begin
                    s_q     <= s_d;
                    state_q <= state_d;
                end
            end else begin
                wr_en_q       <= 1'b0;
                rd_en_q       <= 1'b0;
                frame_start_q <= 1'b0;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign shift_off   = shift_off_q;

endmodule

// File: tb/tb_phasecomp_ctrl.sv
// Directed bench for phasecomp_ctrl: M=8/D=6 instance plus an M=16/D=12 instance.
module tb_phasecomp_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        dv = 1'b0;
    logic [15:0] din = '0;
    logic        wr_en, rd_en, dout_valid, frame_start;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [2:0]  shift_off;

    logic        clr2 = 1'b0;
    logic        dv2 = 1'b0;
    logic [15:0] din2 = '0;
    logic        wr_en2, rd_en2, dout_valid2, frame_start2;
    logic [4:0]  wr_addr2, rd_addr2;
    logic [15:0] wr_data2;
    logic [3:0]  shift_off2;

    int checks = 0;
    int errors = 0;

    int exp_rd [32] = '{5,4,3,2,1,0,7,6, 11,10,9,8,15,14,13,12,
                        1,0,7,6,5,4,3,2, 15,14,13,12,11,10,9,8};
    int exp_s  [4]  = '{6,4,2,0};
    int exp2_rd[5]  = '{11,23,3,31,11};
    int exp2_s [5]  = '{12,8,4,0,12};

    always #5 clk = ~clk;

    phasecomp_ctrl #(.M(8), .D(6), .WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .din(din), .din_valid(dv),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout_valid(dout_valid),
        .frame_start(frame_start), .shift_off(shift_off)
    );

    phasecomp_ctrl #(.M(16), .D(12), .WIDTH(16)) dut2 (
        .clk(clk), .rstn(rstn), .clr(clr2), .din(din2), .din_valid(dv2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .dout_valid(dout_valid2),
        .frame_start(frame_start2), .shift_off(shift_off2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [15:0] d);
        @(negedge clk);
        dv = v; clr = c; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v, input logic [15:0] d);
        @(negedge clk);
        dv2 = v; din2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_shift_off"}, int'(shift_off), 0);
    endtask

    // One prime frame: addresses 0..7, no reads, frame_start only on k=0.
    task automatic prime_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h100 + 16'(i));
            chk({tag, "_wr_en"}, int'(wr_en), 1);
            chk({tag, "_wr_addr"}, int'(wr_addr), i);
            chk({tag, "_wr_data"}, int'(wr_data), 16'h100 + i);
            chk({tag, "_rd_en"}, int'(rd_en), 0);
            chk({tag, "_dout_valid"}, int'(dout_valid), 0);
            chk({tag, "_frame_start"}, int'(frame_start), (i == 0) ? 1 : 0);
            chk({tag, "_shift_off"}, int'(shift_off), 0);
        end
    endtask

    initial begin
        #2;
        all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        prime_frame("t1");

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 16'h200 + 16'(i));
            chk("t2_wr_addr", int'(wr_addr), (8 + i) % 16);
            chk("t2_rd_en", int'(rd_en), 1);
            chk("t2_rd_addr", int'(rd_addr), exp_rd[i]);
            chk("t2_shift_off", int'(shift_off), exp_s[i / 8]);
            chk("t2_frame_start", int'(frame_start), (i % 8 == 0) ? 1 : 0);
            chk("t2_dout_valid", int'(dout_valid), (i > 0) ? 1 : 0);
        end
        step(1'b0, 1'b0, '0);
        chk("t2_idle_wr_en", int'(wr_en), 0);
        chk("t2_idle_rd_en", int'(rd_en), 0);
        chk("t2_idle_dout_valid", int'(dout_valid), 1);
        step(1'b0, 1'b0, '0);
        chk("t2_idle2_dout_valid", int'(dout_valid), 0);

        // Fresh start, then frame 1 with a gap after every sample.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        prime_frame("t3p");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h300 + 16'(i));
            chk("t3_rd_en", int'(rd_en), 1);
            chk("t3_rd_addr", int'(rd_addr), exp_rd[i]);
            chk("t3_wr_addr", int'(wr_addr), 8 + i);
            chk("t3_dout_valid_on", int'(dout_valid), 0);
            step(1'b0, 1'b0, '0);
            chk("t3_gap_rd_en", int'(rd_en), 0);
            chk("t3_gap_wr_en", int'(wr_en), 0);
            chk("t3_gap_dout_valid", int'(dout_valid), 1);
            chk("t3_gap_rd_addr_hold", int'(rd_addr), exp_rd[i]);
        end

        // Frame 2 interrupted by clr on sample 3.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h400 + 16'(i));
            chk("t4_rd_addr", int'(rd_addr), exp_rd[8 + i]);
        end
        step(1'b1, 1'b1, 16'h403);
        chk("t4_clr_wr_en", int'(wr_en), 0);
        chk("t4_clr_rd_en", int'(rd_en), 0);
        chk("t4_clr_shift_off", int'(shift_off), 0);
        chk("t4_clr_dout_valid", int'(dout_valid), 1);
        prime_frame("t4p");
        step(1'b1, 1'b0, 16'h500);
        chk("t4_f1_rd_addr", int'(rd_addr), 5);
        chk("t4_f1_shift_off", int'(shift_off), 6);

        // Asynchronous reset in the middle of frame 1.
        step(1'b1, 1'b0, 16'h501);
        step(1'b1, 1'b0, 16'h502);
        rstn = 1'b0;
        #1;
        all_zero("t5_async");
        @(posedge clk);
        @(negedge clk);
        dv = 1'b0;
        rstn = 1'b1;
        prime_frame("t5p");
        step(1'b1, 1'b0, 16'h600);
        chk("t5_f1_rd_addr", int'(rd_addr), 5);
        chk("t5_f1_shift_off", int'(shift_off), 6);
        step(1'b0, 1'b0, '0);

        // Larger configuration: shift offsets 12,8,4,0 and opposite-bank reads.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 16; k++) begin
                step2(1'b1, 16'(f * 16 + k));
                chk("t6_wr_addr", int'(wr_addr2), (f * 16 + k) % 32);
                if (f == 0) begin
                    chk("t6_prime_rd_en", int'(rd_en2), 0);
                end else begin
                    chk("t6_rd_bank", int'(rd_addr2[4]), (f % 2 == 1) ? 0 : 1);
                    if (k == 0) begin
                        chk("t6_rd_addr_k0", int'(rd_addr2), exp2_rd[f - 1]);
                        chk("t6_shift_off", int'(shift_off2), exp2_s[f - 1]);
                    end
                end
            end
        end
        step2(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
